// File: rtl/grid_mover_pkg.sv
// rtl/grid_mover_pkg.sv - shared direction indices and mover state encoding
package grid_mover_pkg;

   localparam int DIR_UP    = 0;
   localparam int DIR_DOWN  = 1;
   localparam int DIR_LEFT  = 2;
   localparam int DIR_RIGHT = 3;

   localparam int CNT_W = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ASK  = 1'b1
   } state_t;

endpackage

// File: rtl/grid_step.sv
// rtl/grid_step.sv - opposing-key cancel, grid bound mask and stepped coordinate
module grid_step
   import grid_mover_pkg::*;
#(
   parameter int COORD_W = 4,
   parameter int GRID_W  = 13,
   parameter int GRID_H  = 12
) (
   input  logic [COORD_W-1:0] pos_x,
   input  logic [COORD_W-1:0] pos_y,
   input  logic [3:0]         move,
   output logic [3:0]         eff_dir,
   output logic [COORD_W-1:0] step_x,
   output logic [COORD_W-1:0] step_y
);

   localparam logic [COORD_W-1:0] MAX_X = COORD_W'(GRID_W - 1);
   localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(GRID_H - 1);

   always_comb begin
      eff_dir = '0;
      eff_dir[DIR_UP]    = move[DIR_UP]    & ~move[DIR_DOWN]  & (pos_y != '0);
      eff_dir[DIR_DOWN]  = move[DIR_DOWN]  & ~move[DIR_UP]    & (pos_y != MAX_Y);
      eff_dir[DIR_LEFT]  = move[DIR_LEFT]  & ~move[DIR_RIGHT] & (pos_x != '0);
      eff_dir[DIR_RIGHT] = move[DIR_RIGHT] & ~move[DIR_LEFT]  & (pos_x != MAX_X);

      step_x = pos_x;
      if (eff_dir[DIR_RIGHT])
         step_x = pos_x + COORD_W'(1);
      else if (eff_dir[DIR_LEFT])
         step_x = pos_x - COORD_W'(1);

      step_y = pos_y;
      if (eff_dir[DIR_DOWN])
         step_y = pos_y + COORD_W'(1);
      else if (eff_dir[DIR_UP])
         step_y = pos_y - COORD_W'(1);
   end

endmodule

// File: rtl/grid_mover.sv
// rtl/grid_mover.sv - held-direction entity mover with checker handshake, auto-repeat and timeout
module grid_mover
   import grid_mover_pkg::*;
#(
   parameter int COORD_W       = 4,
   parameter int GRID_W        = 13,
   parameter int GRID_H        = 12,
   parameter int START_X       = 6,
   parameter int START_Y       = 11,
   parameter int REPEAT_DELAY  = 8,
   parameter int REPEAT_PERIOD = 4,
   parameter int TIMEOUT       = 16
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [3:0]         move,
   input  logic               load,
   input  logic [COORD_W-1:0] load_x,
   input  logic [COORD_W-1:0] load_y,
   output logic               ask_valid,
   output logic [COORD_W-1:0] ask_x,
   output logic [COORD_W-1:0] ask_y,
   input  logic               resp_accept,
   input  logic               resp_reject,
   input  logic [COORD_W-1:0] resp_x,
   input  logic [COORD_W-1:0] resp_y,
   output logic [COORD_W-1:0] pos_x,
   output logic [COORD_W-1:0] pos_y,
   output logic               moved,
   output logic               rejected,
   output logic               timed_out
);

   state_t             state, state_nxt;
   logic [COORD_W-1:0] pos_x_nxt, pos_y_nxt, ask_x_nxt, ask_y_nxt;
   logic               moved_nxt, rejected_nxt, timed_out_nxt;
   logic [CNT_W-1:0]   rep_cnt, rep_cnt_nxt, tmo_cnt, tmo_cnt_nxt;
   logic               rep_phase, rep_phase_nxt;
   logic [3:0]         last_dir, last_dir_nxt;
   logic [3:0]         eff_dir;
   logic [COORD_W-1:0] step_x, step_y;
   logic               rep_hit;

   grid_step #(
      .COORD_W (COORD_W),
      .GRID_W  (GRID_W),
      .GRID_H  (GRID_H)
   ) u_step (
      .pos_x   (pos_x),
      .pos_y   (pos_y),
      .move    (move),
      .eff_dir (eff_dir),
      .step_x  (step_x),
      .step_y  (step_y)
   );

   // rep_cnt counts idle cycles already spent holding; the issuing cycle is the last one counted
   assign rep_hit = (REPEAT_DELAY != 0) &&
                    (rep_phase ? (rep_cnt == CNT_W'(REPEAT_PERIOD - 1))
                               : (rep_cnt == CNT_W'(REPEAT_DELAY - 1)));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         pos_x     <= COORD_W'(START_X);
         pos_y     <= COORD_W'(START_Y);
         ask_x     <= '0;
         ask_y     <= '0;
         moved     <= 1'b0;
         rejected  <= 1'b0;
         timed_out <= 1'b0;
         rep_cnt   <= '0;
         tmo_cnt   <= '0;
         rep_phase <= 1'b0;
         last_dir  <= '0;
      end else begin
         state     <= state_nxt;
         pos_x     <= pos_x_nxt;
         pos_y     <= pos_y_nxt;
         ask_x     <= ask_x_nxt;
         ask_y     <= ask_y_nxt;
         moved     <= moved_nxt;
         rejected  <= rejected_nxt;
         timed_out <= timed_out_nxt;
         rep_cnt   <= rep_cnt_nxt;
         tmo_cnt   <= tmo_cnt_nxt;
         rep_phase <= rep_phase_nxt;
         last_dir  <= last_dir_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      pos_x_nxt     = pos_x;
      pos_y_nxt     = pos_y;
      ask_x_nxt     = ask_x;
      ask_y_nxt     = ask_y;
      moved_nxt     = 1'b0;
      rejected_nxt  = 1'b0;
      timed_out_nxt = 1'b0;
      rep_cnt_nxt   = rep_cnt;
      tmo_cnt_nxt   = tmo_cnt;
      rep_phase_nxt = rep_phase;
      last_dir_nxt  = last_dir;

      if (load) begin
         state_nxt     = ST_IDLE;
         pos_x_nxt     = load_x;
         pos_y_nxt     = load_y;
         rep_cnt_nxt   = '0;
         tmo_cnt_nxt   = '0;
         rep_phase_nxt = 1'b0;
         last_dir_nxt  = move;
      end else begin
         case (state)
            ST_IDLE: begin
               if (move == 4'b0000) begin
                  last_dir_nxt  = '0;
                  rep_cnt_nxt   = '0;
                  rep_phase_nxt = 1'b0;
               end else if (move != last_dir) begin
                  rep_cnt_nxt   = '0;
                  rep_phase_nxt = 1'b0;
                  if (eff_dir != 4'b0000) begin
                     state_nxt    = ST_ASK;
                     ask_x_nxt    = step_x;
                     ask_y_nxt    = step_y;
                     last_dir_nxt = move;
                     tmo_cnt_nxt  = '0;
                  end
               end else if (rep_hit) begin
                  // a blocked repeat holds the count so it fires as soon as the way clears
                  if (eff_dir != 4'b0000) begin
                     state_nxt     = ST_ASK;
                     ask_x_nxt     = step_x;
                     ask_y_nxt     = step_y;
                     rep_cnt_nxt   = '0;
                     rep_phase_nxt = 1'b1;
                     tmo_cnt_nxt   = '0;
                  end
               end else if (REPEAT_DELAY != 0) begin
                  rep_cnt_nxt = rep_cnt + CNT_W'(1);
               end
            end
            ST_ASK: begin
               if (resp_accept) begin
                  state_nxt = ST_IDLE;
                  pos_x_nxt = resp_x;
                  pos_y_nxt = resp_y;
                  moved_nxt = 1'b1;
               end else if (resp_reject) begin
                  state_nxt    = ST_IDLE;
                  rejected_nxt = 1'b1;
               end else if (TIMEOUT != 0) begin
                  if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                     state_nxt     = ST_IDLE;
                     timed_out_nxt = 1'b1;
                  end else begin
                     tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
                  end
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      ask_valid = (state == ST_ASK);
   end

endmodule

// File: tb/tb_grid_mover.sv
// tb/tb_grid_mover.sv - directed and randomized checks of grid_mover against a behavioural model
module tb_grid_mover;

   localparam int GW = 13;
   localparam int GH = 12;
   localparam int RD = 8;
   localparam int RP = 4;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [3:0] move = '0;
   logic       load = 1'b0;
   logic [3:0] load_x = '0, load_y = '0;
   logic       ask_valid;
   logic [3:0] ask_x, ask_y;
   logic       resp_accept = 1'b0, resp_reject = 1'b0;
   logic [3:0] resp_x = '0, resp_y = '0;
   logic [3:0] pos_x, pos_y;
   logic       moved, rejected, timed_out;

   int n_vec = 0;
   int n_err = 0;

   // behavioural reference state
   int         m_x, m_y, m_ax, m_ay, m_wait, m_idle;
   logic       m_busy, m_rep, m_moved, m_rej, m_to;
   logic [3:0] m_held;

   int ask_idx[$];
   int ask_cnt;

   grid_mover dut (
      .clk         (clk),
      .rstn        (rstn),
      .move        (move),
      .load        (load),
      .load_x      (load_x),
      .load_y      (load_y),
      .ask_valid   (ask_valid),
      .ask_x       (ask_x),
      .ask_y       (ask_y),
      .resp_accept (resp_accept),
      .resp_reject (resp_reject),
      .resp_x      (resp_x),
      .resp_y      (resp_y),
      .pos_x       (pos_x),
      .pos_y       (pos_y),
      .moved       (moved),
      .rejected    (rejected),
      .timed_out   (timed_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_x = 6; m_y = 11; m_ax = 0; m_ay = 0; m_wait = 0; m_idle = 0;
      m_busy = 1'b0; m_rep = 1'b0; m_moved = 1'b0; m_rej = 1'b0; m_to = 1'b0;
      m_held = '0;
   endtask

   task automatic model_step();
      int   dx, dy;
      logic fire;
      m_moved = 1'b0; m_rej = 1'b0; m_to = 1'b0;
      if (load) begin
         m_x = int'(load_x); m_y = int'(load_y);
         m_busy = 1'b0; m_wait = 0; m_idle = 0; m_rep = 1'b0; m_held = move;
      end else if (m_busy) begin
         m_wait++;
         if (resp_accept) begin
            m_x = int'(resp_x); m_y = int'(resp_y); m_moved = 1'b1; m_busy = 1'b0;
         end else if (resp_reject) begin
            m_rej = 1'b1; m_busy = 1'b0;
         end else if (m_wait == TO) begin
            m_to = 1'b1; m_busy = 1'b0;
         end
      end else if (move == 4'b0000) begin
         m_held = '0; m_idle = 0; m_rep = 1'b0;
      end else begin
         dx = int'(move[3]) - int'(move[2]);
         dy = int'(move[1]) - int'(move[0]);
         if (m_x + dx < 0 || m_x + dx > GW - 1) dx = 0;
         if (m_y + dy < 0 || m_y + dy > GH - 1) dy = 0;
         fire = 1'b0;
         if (move != m_held) begin
            m_idle = 0; m_rep = 1'b0;
            fire = (dx != 0 || dy != 0);
         end else begin
            m_idle++;
            if (m_idle >= (m_rep ? RP : RD) && (dx != 0 || dy != 0)) begin
               fire = 1'b1; m_rep = 1'b1;
            end
         end
         if (fire) begin
            m_busy = 1'b1; m_ax = m_x + dx; m_ay = m_y + dy;
            m_held = move; m_wait = 0; m_idle = 0;
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("m_ask_valid", 16'(ask_valid), 16'(m_busy));
      check("m_pos_x", 16'(pos_x), 16'(m_x));
      check("m_pos_y", 16'(pos_y), 16'(m_y));
      check("m_moved", 16'(moved), 16'(m_moved));
      check("m_rejected", 16'(rejected), 16'(m_rej));
      check("m_timed_out", 16'(timed_out), 16'(m_to));
      if (m_busy) begin
         check("m_ask_x", 16'(ask_x), 16'(m_ax));
         check("m_ask_y", 16'(ask_y), 16'(m_ay));
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      check("rst_pos_x", 16'(pos_x), 16'd6);
      check("rst_pos_y", 16'(pos_y), 16'd11);
      check("rst_ask_valid", 16'(ask_valid), 16'd0);
      check("rst_ask_x", 16'(ask_x), 16'd0);
      check("rst_pulses", 16'({moved, rejected, timed_out}), 16'd0);

      // basic right step and accept
      move = 4'b1000;
      cyc();
      check("t1_ask_valid", 16'(ask_valid), 16'd1);
      check("t1_ask_x", 16'(ask_x), 16'd7);
      check("t1_ask_y", 16'(ask_y), 16'd11);
      move = 4'b0000; resp_accept = 1'b1; resp_x = 4'd7; resp_y = 4'd11;
      cyc();
      check("t1_pos_x", 16'(pos_x), 16'd7);
      check("t1_moved", 16'(moved), 16'd1);
      check("t1_ask_drop", 16'(ask_valid), 16'd0);
      resp_accept = 1'b0;
      cyc();
      check("t1_moved_end", 16'(moved), 16'd0);

      // corner: out-of-bounds mask and opposing cancel
      load = 1'b1; load_x = 4'd12; load_y = 4'd0;
      cyc();
      load = 1'b0;
      check("t2_load_x", 16'(pos_x), 16'd12);
      check("t2_load_y", 16'(pos_y), 16'd0);
      move = 4'b1001;
      cyc(); cyc();
      check("t2_oob_no_ask", 16'(ask_valid), 16'd0);
      move = 4'b0011;
      cyc(); cyc();
      check("t2_cancel_no_ask", 16'(ask_valid), 16'd0);
      move = 4'b0000;
      cyc();

      // typematic repeat with an immediately granting checker
      move = 4'b0100;
      ask_idx.delete();
      for (int i = 0; i < 24; i++) begin
         cyc();
         if (ask_valid === 1'b1) ask_idx.push_back(i);
         resp_accept = ask_valid;
         resp_x = ask_x; resp_y = ask_y;
         if (i == 23) move = 4'b0000;
      end
      resp_accept = 1'b0;
      check("t3_ask_count", 16'(ask_idx.size()), 16'd4);
      if (ask_idx.size() == 4) begin
         check("t3_first", 16'(ask_idx[0]), 16'd0);
         check("t3_delay", 16'(ask_idx[1]), 16'd9);
         check("t3_period1", 16'(ask_idx[2]), 16'd14);
         check("t3_period2", 16'(ask_idx[3]), 16'd19);
      end
      ask_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (ask_valid === 1'b1) ask_cnt++;
      end
      check("t3_release_quiet", 16'(ask_cnt), 16'd0);
      check("t3_pos_x", 16'(pos_x), 16'd8);

      // timeout, then accept winning over reject
      move = 4'b1000;
      cyc();
      move = 4'b0000;
      check("t4_ask_x", 16'(ask_x), 16'd9);
      for (int i = 2; i <= 16; i++) begin
         cyc();
         check("t4_still_asking", 16'(ask_valid), 16'd1);
      end
      cyc();
      check("t4_timed_out", 16'(timed_out), 16'd1);
      check("t4_ask_drop", 16'(ask_valid), 16'd0);
      check("t4_pos_kept", 16'(pos_x), 16'd8);
      cyc();
      check("t4_pulse_end", 16'(timed_out), 16'd0);
      move = 4'b0010;
      cyc();
      move = 4'b0000;
      check("t4_ask_y", 16'(ask_y), 16'd1);
      resp_accept = 1'b1; resp_reject = 1'b1; resp_x = 4'd8; resp_y = 4'd1;
      cyc();
      resp_accept = 1'b0; resp_reject = 1'b0;
      check("t4_both_moved", 16'(moved), 16'd1);
      check("t4_both_not_rej", 16'(rejected), 16'd0);
      check("t4_both_pos_y", 16'(pos_y), 16'd1);

      // load beats a same-cycle accept
      move = 4'b0001;
      cyc();
      move = 4'b0000;
      check("t5_asking", 16'(ask_valid), 16'd1);
      load = 1'b1; load_x = 4'd3; load_y = 4'd3;
      resp_accept = 1'b1; resp_x = 4'd8; resp_y = 4'd0;
      cyc();
      load = 1'b0; resp_accept = 1'b0;
      check("t5_pos_x", 16'(pos_x), 16'd3);
      check("t5_pos_y", 16'(pos_y), 16'd3);
      check("t5_no_ask", 16'(ask_valid), 16'd0);
      check("t5_no_moved", 16'(moved), 16'd0);
      cyc();

      // asynchronous reset while asking
      move = 4'b1000;
      cyc();
      move = 4'b0000;
      check("t6_asking", 16'(ask_valid), 16'd1);
      #2 rstn = 1'b0;
      #1 check("t6_async_drop", 16'(ask_valid), 16'd0);
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      check("t6_pos_x", 16'(pos_x), 16'd6);
      check("t6_pos_y", 16'(pos_y), 16'd11);
      cyc();

      // randomized traffic against the model
      for (int i = 0; i < 1600; i++) begin
         bit quiet;
         quiet = ((i / 200) % 2) == 1;
         if ($urandom_range(99, 0) >= 95)
            move = ($urandom_range(4, 0) == 0) ? 4'b0000 : 4'($urandom_range(15, 1));
         load = ($urandom_range(59, 0) == 0);
         load_x = 4'($urandom_range(GW - 1, 0));
         load_y = 4'($urandom_range(GH - 1, 0));
         resp_accept = quiet ? ($urandom_range(39, 0) == 0) : ($urandom_range(3, 0) == 0);
         resp_reject = quiet ? ($urandom_range(39, 0) == 0) : ($urandom_range(5, 0) == 0);
         resp_x = 4'($urandom_range(GW - 1, 0));
         resp_y = 4'($urandom_range(GH - 1, 0));
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
